add8_err_monitor: RTL and testbench

Streaming error-statistics stage placed directly downstream of an 8-bit approximate adder. Each accepted sample carries the adder's operands and its 9-bit approximate result. The block recomputes the exact sum and accumulates the worst-case error, sum of absolute errors and erroneous-sample count over a fixed window. The window totals are presented through a valid/ack handshake for on-line characterisation (WCE/MAE/EP) of the adder in silicon or FPGA.

---
 rtl/add8_err_monitor.sv | 199 +++++++++++++++++++
 tb/tb_add8_err_monitor.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_err_monitor.sv
// add8_err_monitor
// Error-statistics stage for an 8-bit approximate adder. Each accepted sample
// (a, b, o_approx) is compared against the exact sum, and the window totals
// (worst-case error, sum of |error|, erroneous-sample count) are presented
// through a stat_valid/stat_ack handshake.
// Optional feature macro: ERR_SSE_EN adds the squared-error datapath, the sse
// accumulator and the sse output port.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; last window totals stay readable
// RUN    | accepting samples until N_SAMPLES have been taken
// DRAIN  | two cycles while the last samples leave the pipeline
// REPORT | totals valid and stable until stat_ack
module add8_err_monitor #(
    parameter int N_SAMPLES = 65536,
    parameter int CNT_W     = 17
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           a,
    input  logic [7:0]           b,
    input  logic [8:0]           o_approx,
    output logic                 busy,
    output logic                 stat_valid,
    input  logic                 stat_ack,
    output logic [8:0]           wce,
    output logic [9+CNT_W-1:0]   sae,
    output logic [CNT_W-1:0]     err_cnt
`ifdef ERR_SSE_EN
    ,
    output logic [18+CNT_W-1:0]  sse
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic               drain_cnt_q, drain_cnt_d;

    logic               accept;
    logic               clear;

    logic               s1_vld_q;
    logic [7:0]         s1_a_q, s1_b_q;
    logic [8:0]         s1_o_q;

    logic [8:0]         s1_sum;
    logic signed [9:0]  s1_err;
    logic [8:0]         s1_abs;

    logic               s2_vld_q;
    logic [8:0]         s2_abs_q;
    logic               s2_nz_q;

    logic [8:0]         wce_q;
    logic [9+CNT_W-1:0] sae_q;
    logic [CNT_W-1:0]   err_cnt_q;

    assign in_ready   = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == DRAIN);
    assign stat_valid = (state_q == REPORT);
    assign accept     = in_valid && in_ready;
    assign clear      = (state_q == IDLE) && start;

    // Next-state logic: accept counting in RUN, fixed two-cycle drain timer.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    acc_cnt_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    if (acc_cnt_q == LAST_CNT) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == 1'b0) begin
                    state_d = REPORT;
                end else begin
                    drain_cnt_d = drain_cnt_q - 1'b1;
                end
            end
            REPORT: begin
                if (stat_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_cnt_q   <= '0;
            drain_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Error is o_approx - (a + b) in 10-bit signed; its magnitude fits 9 bits.
    assign s1_sum = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign s1_err = $signed({1'b0, s1_o_q}) - $signed({1'b0, s1_sum});
    assign s1_abs = s1_err[9] ? 9'(-s1_err) : s1_err[8:0];

    // S1 captures accepted samples, S2 holds |err|; both advance every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_o_q   <= '0;
            s2_vld_q <= 1'b0;
            s2_abs_q <= '0;
            s2_nz_q  <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_a_q <= a;
                s1_b_q <= b;
                s1_o_q <= o_approx;
            end
            s2_vld_q <= s1_vld_q;
            s2_abs_q <= s1_abs;
            s2_nz_q  <= (s1_abs != 9'd0);
        end
    end

    // S3 accumulators; only valid-tagged entries contribute.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wce_q     <= '0;
            sae_q     <= '0;
            err_cnt_q <= '0;
        end else if (s2_vld_q) begin
            if (s2_abs_q > wce_q) begin
                wce_q <= s2_abs_q;
            end
            sae_q     <= sae_q + (9+CNT_W)'(s2_abs_q);
            err_cnt_q <= err_cnt_q + CNT_W'(s2_nz_q);
        end
    end

    assign wce     = wce_q;
    assign sae     = sae_q;
    assign err_cnt = err_cnt_q;

`ifdef ERR_SSE_EN
    logic [17:0]         s2_sq_q;
    logic [18+CNT_W-1:0] sse_q;

    // err^2 computed from |err|: identical value, and 511^2 fits in 18 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_sq_q <= '0;
        end else begin
            s2_sq_q <= {9'd0, s1_abs} * {9'd0, s1_abs};
        end
    end

    // Squared-error accumulator, cleared with the other totals.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            sse_q <= '0;
        end else if (s2_vld_q) begin
            sse_q <= sse_q + (18+CNT_W)'(s2_sq_q);
        end
    end

    assign sse = sse_q;
`endif

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor with a 4-sample window. A reference
// model computes each window's totals as samples are accepted and pushes them
// to a scoreboard queue; they are popped when the DUT reports.
module tb_add8_err_monitor;

    localparam int N  = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic              stat_ack = 1'b0;
    logic [7:0]        a = '0;
    logic [7:0]        b = '0;
    logic [8:0]        o_approx = '0;
    logic              in_ready;
    logic              busy;
    logic              stat_valid;
    logic [8:0]        wce;
    logic [9+CW-1:0]   sae;
    logic [CW-1:0]     err_cnt;
`ifdef ERR_SSE_EN
    logic [18+CW-1:0]  sse;
`endif

    add8_err_monitor #(.N_SAMPLES(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .o_approx   (o_approx),
        .busy       (busy),
        .stat_valid (stat_valid),
        .stat_ack   (stat_ack),
        .wce        (wce),
        .sae        (sae),
        .err_cnt    (err_cnt)
`ifdef ERR_SSE_EN
        ,
        .sse        (sse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int wce;
        int sae;
        int cnt;
        int sse;
    } tot_t;

    tot_t exp_q[$];
    tot_t cur;
    int   checks = 0;
    int   errors = 0;
    int   m_wce, m_sae, m_cnt, m_sse, m_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_wce = 0; m_sae = 0; m_cnt = 0; m_sse = 0; m_acc = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int sa, input int sb, input int so);
        logic acc;
        int   e;
        int   ae;
        acc = 1'b0;
        in_valid = 1'b1;
        a = 8'(sa);
        b = 8'(sb);
        o_approx = 9'(so);
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
        end else begin
            e  = so - (sa + sb);
            ae = (e < 0) ? -e : e;
            if (ae > m_wce) m_wce = ae;
            m_sae += ae;
            if (ae != 0) m_cnt++;
            m_sse += e * e;
            m_acc++;
            if (m_acc == N) begin
                cur.wce = m_wce; cur.sae = m_sae; cur.cnt = m_cnt; cur.sse = m_sse;
                exp_q.push_back(cur);
            end
        end
    endtask

    // Called just after the last accept edge k: report must appear at k+2.
    task automatic check_report(input string tag);
        chk({tag, "_drain_k"}, 64'(stat_valid), 64'd0);
        chk({tag, "_busy_drain"}, 64'(busy), 64'd1);
        tick();
        chk({tag, "_drain_k1"}, 64'(stat_valid), 64'd0);
        tick();
        chk({tag, "_report_k2"}, 64'(stat_valid), 64'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            cur = exp_q.pop_front();
            chk({tag, "_wce"}, 64'(wce), 64'(cur.wce));
            chk({tag, "_sae"}, 64'(sae), 64'(cur.sae));
            chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(cur.cnt));
`ifdef ERR_SSE_EN
            chk({tag, "_sse"}, 64'(sse), 64'(cur.sse));
`endif
        end
    endtask

    task automatic do_ack(input string tag);
        stat_ack = 1'b1;
        tick();
        stat_ack = 1'b0;
        chk({tag, "_ack_valid"}, 64'(stat_valid), 64'd0);
        chk({tag, "_ack_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stat_valid", 64'(stat_valid), 64'd0);
        chk("rst_wce", 64'(wce), 64'd0);
        chk("rst_sae", 64'(sae), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
`ifdef ERR_SSE_EN
        chk("rst_sse", 64'(sse), 64'd0);
`endif

        // No acceptance in IDLE
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("idle_in_ready", 64'(in_ready), 64'd0);

        // Window 1: mixed errors 0, +3, -5, +19
        pulse_start();
        model_clear();
        chk("w1_in_ready_after_start", 64'(in_ready), 64'd1);
        chk("w1_busy", 64'(busy), 64'd1);
        send(10, 20, 30);
        send(100, 50, 153);
        send(7, 8, 10);
        send(200, 100, 319);
        check_report("w1");
        chk("w1_wce_const", 64'(wce), 64'd19);
        chk("w1_sae_const", 64'(sae), 64'd27);

        // Hold in REPORT for 10 cycles; a start pulse in between is ignored
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            tick();
            chk("hold_stat_valid", 64'(stat_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_wce", 64'(wce), 64'(cur.wce));
            chk("hold_sae", 64'(sae), 64'(cur.sae));
        end
        start = 1'b0;
        do_ack("w1");
        chk("w1_retain_wce", 64'(wce), 64'd19);
        chk("w1_retain_sae", 64'(sae), 64'd27);
        chk("w1_retain_cnt", 64'(err_cnt), 64'd3);

        // Window 2: same stream with idle gaps between samples
        pulse_start();
        model_clear();
        send(10, 20, 30);
        tick();
        send(100, 50, 153);
        tick();
        send(7, 8, 10);
        tick();
        send(200, 100, 319);
        check_report("w2");
        do_ack("w2");

        // Window 3: error +1 on every sample at the operand maximum
        pulse_start();
        model_clear();
        for (int i = 0; i < N; i++) send(255, 255, 511);
        check_report("w3");
        do_ack("w3");

        // Window 4: +511 errors, start pulsed mid-RUN must not clear
        pulse_start();
        model_clear();
        send(0, 0, 511);
        send(0, 0, 511);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_start_busy", 64'(busy), 64'd1);
        send(0, 0, 511);
        send(255, 255, 511);
        check_report("w4");
        chk("w4_wce_max", 64'(wce), 64'd511);
        do_ack("w4");

        // Reset mid-window discards partial totals
        pulse_start();
        model_clear();
        send(100, 50, 153);
        send(7, 8, 10);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_stat_valid", 64'(stat_valid), 64'd0);
        chk("mid_rst_wce", 64'(wce), 64'd0);
        chk("mid_rst_sae", 64'(sae), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_no_report", 64'(stat_valid), 64'd0);
        end

        // Fresh window of zero-error samples
        pulse_start();
        model_clear();
        send(1, 2, 3);
        send(0, 0, 0);
        send(128, 127, 255);
        send(255, 1, 256);
        check_report("w5");
        do_ack("w5");
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
